// File: rtl/jpeg_byte_feeder_if.sv
`default_nettype none
// ============================================================================
// Module   : jpeg_byte_feeder_if
// Brief    : Control, memory-read and parser-side byte bus of jpeg_byte_feeder.
// Revision : 1.0
// ============================================================================
interface jpeg_byte_feeder_if #(
    parameter int ADDR_W = 16
) ();
    logic              i_start;
    logic              i_abort;
    logic [ADDR_W-1:0] i_len;
    logic              o_rd_en;
    logic [ADDR_W-1:0] o_rd_addr;
    logic [7:0]        i_rd_data;
    logic              o_byte_en;
    logic [7:0]        o_byte;
    logic              i_jfif_ready;
    logic              o_busy;
    logic              o_done;
    logic              o_eoi_err;
    logic [ADDR_W-1:0] o_byte_cnt;

    modport master (
        output i_start, i_abort, i_len, i_rd_data, i_jfif_ready,
        input  o_rd_en, o_rd_addr, o_byte_en, o_byte, o_busy, o_done,
               o_eoi_err, o_byte_cnt
    );

    modport slave (
        input  i_start, i_abort, i_len, i_rd_data, i_jfif_ready,
        output o_rd_en, o_rd_addr, o_byte_en, o_byte, o_busy, o_done,
               o_eoi_err, o_byte_cnt
    );
endinterface
`default_nettype wire

// File: rtl/jpeg_byte_feeder.sv
`default_nettype none
// ============================================================================
// Module   : jpeg_byte_feeder
// Brief    : Streams one JPEG file from byte memory to the JFIF parser through
//            a small FIFO, ending on the FF D9 marker or on length exhaustion.
// Revision : 1.0
// ============================================================================
module jpeg_byte_feeder #(
    parameter int ADDR_W     = 16,
    parameter int FIFO_DEPTH = 4
) (
    input  wire               i_sysclk,
    input  wire               i_arst,
    jpeg_byte_feeder_if.slave bus
);
    localparam int c_ptr_w = $clog2(FIFO_DEPTH);
    localparam int c_cnt_w = c_ptr_w + 1;
    localparam logic [c_cnt_w-1:0] c_depth = c_cnt_w'(FIFO_DEPTH);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t             r_state;
    state_t             w_state_next;
    logic [ADDR_W-1:0]  r_rd_addr;
    logic [ADDR_W-1:0]  r_len;
    logic [ADDR_W-1:0]  r_byte_cnt;
    logic               r_inflight;
    logic               r_prev_ff;
    logic               r_eoi_err;
    logic [7:0]         r_mem [FIFO_DEPTH];
    logic [c_ptr_w-1:0] r_wr_ptr;
    logic [c_ptr_w-1:0] r_rd_ptr;
    logic [c_cnt_w-1:0] r_count;

    logic               w_run;
    logic               w_abort;
    logic               w_start_ok;
    logic               w_fifo_empty;
    logic [7:0]         w_head;
    logic               w_byte_en;
    logic               w_xfer;
    logic               w_eoi;
    logic               w_exhaust;
    logic               w_push;
    logic               w_flush;
    logic [c_cnt_w-1:0] w_occ;
    logic               w_rd_en;

    assign w_run        = (r_state == RUN);
    assign w_abort      = bus.i_abort & (r_state != IDLE);
    assign w_start_ok   = (r_state == IDLE) & bus.i_start;
    assign w_fifo_empty = (r_count == '0);
    assign w_head       = r_mem[r_rd_ptr];
    assign w_byte_en    = w_run & ~w_fifo_empty;
    assign w_xfer       = w_byte_en & bus.i_jfif_ready;
    assign w_eoi        = w_xfer & r_prev_ff & (w_head == 8'hD9);
    assign w_exhaust    = w_run & (r_rd_addr == r_len) & w_fifo_empty & ~r_inflight;
    // Returns that land outside RUN belong to a finished or aborted file.
    assign w_push       = r_inflight & w_run;
    assign w_flush      = w_abort | w_eoi | w_start_ok;

    // Occupancy the FIFO will have once everything already requested lands.
    assign w_occ   = r_count + c_cnt_w'(r_inflight) - c_cnt_w'(w_xfer);
    assign w_rd_en = w_run & ~bus.i_abort & ~w_eoi
                   & (r_rd_addr < r_len) & (w_occ < c_depth);

    always_ff @(posedge i_sysclk or posedge i_arst) begin
        if (i_arst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            IDLE: begin
                if (bus.i_start) begin
                    w_state_next = (bus.i_len != '0) ? RUN : DONE;
                end
            end
            RUN: begin
                if (w_abort) begin
                    w_state_next = IDLE;
                end else if (w_eoi || w_exhaust) begin
                    w_state_next = DONE;
                end
            end
            DONE:    w_state_next = IDLE;
            default: w_state_next = IDLE;
        endcase
    end

    always_ff @(posedge i_sysclk or posedge i_arst) begin
        if (i_arst) begin
            r_rd_addr  <= '0;
            r_len      <= '0;
            r_byte_cnt <= '0;
            r_inflight <= 1'b0;
            r_prev_ff  <= 1'b0;
            r_eoi_err  <= 1'b0;
        end else if (w_start_ok) begin
            r_rd_addr  <= '0;
            r_len      <= bus.i_len;
            r_byte_cnt <= '0;
            r_inflight <= 1'b0;
            r_prev_ff  <= 1'b0;
            r_eoi_err  <= (bus.i_len == '0);
        end else begin
            r_inflight <= w_rd_en;
            if (w_rd_en) begin
                r_rd_addr <= r_rd_addr + ADDR_W'(1);
            end
            if (w_xfer) begin
                r_prev_ff <= (w_head == 8'hFF);
                if (r_byte_cnt != '1) begin
                    r_byte_cnt <= r_byte_cnt + ADDR_W'(1);
                end
            end
            if (w_exhaust && !w_abort) begin
                r_eoi_err <= 1'b1;
            end
        end
    end

    always_ff @(posedge i_sysclk or posedge i_arst) begin
        if (i_arst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else if (w_flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + c_ptr_w'(1);
            end
            if (w_xfer) begin
                r_rd_ptr <= r_rd_ptr + c_ptr_w'(1);
            end
            r_count <= r_count + c_cnt_w'(w_push) - c_cnt_w'(w_xfer);
        end
    end

    always_ff @(posedge i_sysclk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= bus.i_rd_data;
        end
    end

    assign bus.o_rd_en    = w_rd_en;
    assign bus.o_rd_addr  = r_rd_addr;
    assign bus.o_byte_en  = w_byte_en;
    assign bus.o_byte     = w_fifo_empty ? 8'h00 : w_head;
    assign bus.o_busy     = (r_state != IDLE);
    assign bus.o_done     = (r_state == DONE) & ~bus.i_abort;
    assign bus.o_eoi_err  = r_eoi_err;
    assign bus.o_byte_cnt = r_byte_cnt;

endmodule
`default_nettype wire

// File: tb/tb_jpeg_byte_feeder.sv
`default_nettype none
// ============================================================================
// Module   : tb_jpeg_byte_feeder
// Brief    : Self-checking bench for jpeg_byte_feeder against a file-level model.
// Revision : 1.0
// ============================================================================
`timescale 1ns/1ps
module tb_jpeg_byte_feeder;
    localparam int AW = 16;

    logic clk = 1'b0;
    logic rst = 1'b0;

    jpeg_byte_feeder_if #(.ADDR_W(AW)) bus ();

    jpeg_byte_feeder #(.ADDR_W(AW), .FIFO_DEPTH(4)) dut (
        .i_sysclk (clk),
        .i_arst   (rst),
        .bus      (bus.slave)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Source memory: data valid exactly one cycle after the read strobe, X otherwise.
    logic [7:0] mem [256];
    logic       pend;
    logic [7:0] pend_addr;
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            pend      <= 1'b0;
            pend_addr <= 8'h00;
        end else begin
            pend      <= bus.o_rd_en;
            pend_addr <= bus.o_rd_addr[7:0];
        end
    end
    assign bus.i_rd_data = pend ? mem[pend_addr] : 8'hxx;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic [7:0] got_q[$];
    int         xfer_cyc_q[$];
    int         en_cyc_q[$];
    int         rd_cyc_q[$];
    int         rd_addr_q[$];
    int         done_cyc_q[$];
    int         done_cnt = 0;
    logic       done_err = 1'b0;
    int         oob_rd = 0;
    int         cur_len = 0;
    int         start_cyc = 0;

    always @(negedge clk) begin
        if (!rst) begin
            if (bus.o_byte_en && bus.i_jfif_ready) begin
                got_q.push_back(bus.o_byte);
                xfer_cyc_q.push_back(cyc);
            end
            if (bus.o_byte_en) en_cyc_q.push_back(cyc);
            if (bus.o_rd_en) begin
                rd_cyc_q.push_back(cyc);
                rd_addr_q.push_back(int'(bus.o_rd_addr));
                if (int'(bus.o_rd_addr) >= cur_len) oob_rd++;
            end
            if (bus.o_done) begin
                done_cnt++;
                done_err = bus.o_eoi_err;
                done_cyc_q.push_back(cyc);
            end
        end
    end

    // File-level reference: bytes in address order until FF followed by D9, else length.
    logic [7:0] exp_q[$];
    logic       exp_err;
    function automatic void build_expect(input int len);
        logic [7:0] prev;
        prev = 8'h00;
        exp_q.delete();
        exp_err = 1'b1;
        for (int a = 0; a < len; a++) begin
            exp_q.push_back(mem[a]);
            if (prev == 8'hFF && mem[a] == 8'hD9) begin
                exp_err = 1'b0;
                break;
            end
            prev = mem[a];
        end
    endfunction

    function automatic bit seq_ok(input int base);
        if (got_q.size() - base != exp_q.size()) return 1'b0;
        foreach (exp_q[i]) if (got_q[base + i] !== exp_q[i]) return 1'b0;
        return 1'b1;
    endfunction

    function automatic int first_en_after(input int c);
        foreach (en_cyc_q[i]) if (en_cyc_q[i] >= c) return en_cyc_q[i];
        return -1;
    endfunction

    function automatic int first_rd_idx_after(input int c);
        foreach (rd_cyc_q[i]) if (rd_cyc_q[i] >= c) return i;
        return -1;
    endfunction

    task automatic start_file(input int len);
        @(posedge clk); #1;
        bus.i_start = 1'b1;
        bus.i_len   = AW'(len);
        cur_len     = len;
        @(posedge clk); #1;
        start_cyc   = cyc;
        bus.i_start = 1'b0;
    endtask

    task automatic wait_done(input int budget, input bit rnd, output bit ok);
        int base;
        base = done_cnt;
        ok   = 1'b0;
        for (int c = 0; c < budget; c++) begin
            @(negedge clk); #1;
            if (done_cnt > base) begin
                ok = 1'b1;
                break;
            end
            @(posedge clk); #1;
            bus.i_jfif_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
        end
    endtask

    task automatic test_reset();
        #1 rst = 1'b1;
        #2;
        checks++; if (bus.o_rd_en !== 1'b0)   begin errors++; $display("FAIL reset rd_en: got %b required 0", bus.o_rd_en); end
        checks++; if (bus.o_rd_addr !== '0)   begin errors++; $display("FAIL reset rd_addr: got %h required 0", bus.o_rd_addr); end
        checks++; if (bus.o_byte_en !== 1'b0) begin errors++; $display("FAIL reset byte_en: got %b required 0", bus.o_byte_en); end
        checks++; if (bus.o_byte !== 8'h00)   begin errors++; $display("FAIL reset byte: got %h required 00", bus.o_byte); end
        checks++; if (bus.o_busy !== 1'b0)    begin errors++; $display("FAIL reset busy: got %b required 0", bus.o_busy); end
        checks++; if (bus.o_done !== 1'b0)    begin errors++; $display("FAIL reset done: got %b required 0", bus.o_done); end
        checks++; if (bus.o_eoi_err !== 1'b0) begin errors++; $display("FAIL reset eoi_err: got %b required 0", bus.o_eoi_err); end
        checks++; if (bus.o_byte_cnt !== '0)  begin errors++; $display("FAIL reset byte_cnt: got %h required 0", bus.o_byte_cnt); end
        @(posedge clk); #1 rst = 1'b0;
        repeat (3) @(posedge clk); #1;
        checks++; if ({bus.o_busy, bus.o_rd_en} !== 2'b00) begin
            errors++; $display("FAIL idle_after_reset: got busy/rd_en %b required 00", {bus.o_busy, bus.o_rd_en});
        end
    endtask

    task automatic test_eoi_stream();
        bit ok;
        int base, nb, db, span, dcyc, ridx;
        foreach (mem[i]) mem[i] = 8'h00;
        {mem[0], mem[1], mem[2], mem[3], mem[4], mem[5]} = {8'hFF, 8'hD8, 8'h00, 8'hFF, 8'hD9, 8'hAA};
        build_expect(6);
        bus.i_jfif_ready = 1'b1;
        base = got_q.size(); nb = xfer_cyc_q.size(); db = done_cyc_q.size();
        start_file(6);
        wait_done(100, 1'b0, ok);
        checks++; if (!ok) begin errors++; $display("FAIL eoi_stream timeout: got no done, required done"); end
        repeat (3) @(posedge clk); #1;
        checks++; if (!seq_ok(base)) begin errors++; $display("FAIL eoi_stream bytes: got %0d bytes, required %0d", got_q.size() - base, exp_q.size()); end
        checks++; if (done_err !== exp_err) begin errors++; $display("FAIL eoi_stream eoi_err: got %b required %b", done_err, exp_err); end
        checks++; if (bus.o_byte_cnt !== AW'(5)) begin errors++; $display("FAIL eoi_stream byte_cnt: got %0d required 5", bus.o_byte_cnt); end
        span = (xfer_cyc_q.size() - nb == 5) ? xfer_cyc_q[nb + 4] - xfer_cyc_q[nb] : -1;
        checks++; if (span != 4) begin errors++; $display("FAIL throughput span: got %0d cycles required 4", span); end
        dcyc = (done_cyc_q.size() > db && xfer_cyc_q.size() > nb) ? done_cyc_q[db] - xfer_cyc_q[xfer_cyc_q.size() - 1] : -1;
        checks++; if (dcyc != 1) begin errors++; $display("FAIL eoi_stream done_timing: got %0d cycles after D9 required 1", dcyc); end
        checks++; if (done_cyc_q.size() - db != 1) begin errors++; $display("FAIL eoi_stream done_pulses: got %0d required 1", done_cyc_q.size() - db); end
        ridx = first_rd_idx_after(start_cyc);
        checks++; if (ridx < 0 || rd_cyc_q[ridx] != start_cyc || rd_addr_q[ridx] != 0) begin
            errors++; $display("FAIL first_read: got idx %0d, required read of address 0 at cycle %0d", ridx, start_cyc);
        end
        checks++; if (bus.o_busy !== 1'b0) begin errors++; $display("FAIL eoi_stream busy_after: got %b required 0", bus.o_busy); end
    endtask

    task automatic test_random_ready();
        bit ok;
        int base, db, len;
        for (int f = 0; f < 18; f++) begin
            foreach (mem[i]) mem[i] = 8'h00;
            if (f < 3) begin
                {mem[0], mem[1], mem[2], mem[3], mem[4], mem[5]} = {8'hFF, 8'hD8, 8'h00, 8'hFF, 8'hD9, 8'hAA};
                len = 6;
            end else begin
                len = $urandom_range(1, 30);
                foreach (mem[i]) begin
                    case ($urandom_range(0, 5))
                        0, 1:    mem[i] = 8'hFF;
                        2:       mem[i] = 8'hD9;
                        default: mem[i] = 8'($urandom);
                    endcase
                end
            end
            build_expect(len);
            base = got_q.size(); db = done_cnt;
            start_file(len);
            wait_done(400, 1'b1, ok);
            repeat (3) @(posedge clk); #1;
            checks++; if (!ok) begin errors++; $display("FAIL random_ready[%0d] timeout: got no done, required done", f); end
            checks++; if (!seq_ok(base)) begin errors++; $display("FAIL random_ready[%0d] bytes: got %0d bytes, required %0d", f, got_q.size() - base, exp_q.size()); end
            checks++; if (done_err !== exp_err) begin errors++; $display("FAIL random_ready[%0d] eoi_err: got %b required %b", f, done_err, exp_err); end
            checks++; if (bus.o_byte_cnt !== AW'(exp_q.size())) begin errors++; $display("FAIL random_ready[%0d] byte_cnt: got %0d required %0d", f, bus.o_byte_cnt, exp_q.size()); end
            checks++; if (done_cnt - db != 1) begin errors++; $display("FAIL random_ready[%0d] done_pulses: got %0d required 1", f, done_cnt - db); end
        end
        checks++; if (oob_rd != 0) begin errors++; $display("FAIL read_beyond_length: got %0d reads required 0", oob_rd); end
    endtask

    task automatic test_exhaust();
        bit ok;
        int base;
        foreach (mem[i]) mem[i] = 8'h00;
        {mem[0], mem[1], mem[2]} = {8'h11, 8'h22, 8'h33};
        build_expect(3);
        bus.i_jfif_ready = 1'b1;
        base = got_q.size();
        start_file(3);
        wait_done(100, 1'b0, ok);
        repeat (2) @(posedge clk); #1;
        checks++; if (!ok) begin errors++; $display("FAIL exhaust timeout: got no done, required done"); end
        checks++; if (!seq_ok(base)) begin errors++; $display("FAIL exhaust bytes: got %0d bytes, required %0d", got_q.size() - base, exp_q.size()); end
        checks++; if (done_err !== 1'b1) begin errors++; $display("FAIL exhaust eoi_err: got %b required 1", done_err); end
        checks++; if (bus.o_eoi_err !== 1'b1) begin errors++; $display("FAIL exhaust eoi_err_held: got %b required 1", bus.o_eoi_err); end
        checks++; if (bus.o_byte_cnt !== AW'(3)) begin errors++; $display("FAIL exhaust byte_cnt: got %0d required 3", bus.o_byte_cnt); end
    endtask

    task automatic test_d9_latency();
        bit ok;
        int base, fen;
        foreach (mem[i]) mem[i] = 8'h55;
        {mem[0], mem[1], mem[2], mem[3]} = {8'hD9, 8'hFF, 8'hFF, 8'hD9};
        build_expect(4);
        bus.i_jfif_ready = 1'b1;
        base = got_q.size();
        start_file(4);
        wait_done(100, 1'b0, ok);
        repeat (2) @(posedge clk); #1;
        fen = first_en_after(start_cyc);
        checks++; if (fen != start_cyc + 2) begin errors++; $display("FAIL latency: got first byte_en at cycle %0d required %0d", fen, start_cyc + 2); end
        checks++; if (!ok || !seq_ok(base)) begin errors++; $display("FAIL d9_seq bytes: got %0d bytes (done %b), required %0d", got_q.size() - base, ok, exp_q.size()); end
        checks++; if (done_err !== 1'b0) begin errors++; $display("FAIL d9_seq eoi_err: got %b required 0", done_err); end
    endtask

    task automatic test_zero_len();
        bit ok;
        int base, db;
        base = got_q.size(); db = done_cyc_q.size();
        start_file(0);
        wait_done(10, 1'b0, ok);
        repeat (3) @(posedge clk); #1;
        checks++; if (!ok || done_cyc_q.size() - db != 1 || done_cyc_q[db] != start_cyc) begin
            errors++; $display("FAIL zero_len done: got %0d pulses, required one pulse at cycle %0d", done_cyc_q.size() - db, start_cyc);
        end
        checks++; if (done_err !== 1'b1) begin errors++; $display("FAIL zero_len eoi_err: got %b required 1", done_err); end
        checks++; if (got_q.size() != base) begin errors++; $display("FAIL zero_len bytes: got %0d required 0", got_q.size() - base); end
    endtask

    task automatic test_abort();
        bit ok;
        int base, db, ridx;
        foreach (mem[i]) mem[i] = 8'h40 + 8'(i);
        bus.i_jfif_ready = 1'b1;
        base = got_q.size(); db = done_cnt;
        start_file(16);
        for (int c = 0; c < 20; c++) begin
            @(negedge clk); #1;
            if (got_q.size() - base >= 1) break;
        end
        @(posedge clk); #1;
        bus.i_abort = 1'b1;
        @(posedge clk); #1;
        bus.i_abort = 1'b0;
        checks++; if ({bus.o_busy, bus.o_byte_en, bus.o_rd_en} !== 3'b000) begin
            errors++; $display("FAIL abort idle: got busy/byte_en/rd_en %b required 000", {bus.o_busy, bus.o_byte_en, bus.o_rd_en});
        end
        repeat (5) @(posedge clk); #1;
        checks++; if (done_cnt != db) begin errors++; $display("FAIL abort done_pulse: got %0d required 0", done_cnt - db); end
        build_expect(16);
        base = got_q.size();
        start_file(16);
        wait_done(200, 1'b0, ok);
        repeat (2) @(posedge clk); #1;
        ridx = first_rd_idx_after(start_cyc);
        checks++; if (ridx < 0 || rd_addr_q[ridx] != 0) begin errors++; $display("FAIL restart address: got idx %0d, required address 0", ridx); end
        checks++; if (!ok || !seq_ok(base)) begin errors++; $display("FAIL restart bytes: got %0d bytes (done %b), required %0d", got_q.size() - base, ok, exp_q.size()); end
        checks++; if (bus.o_byte_cnt !== AW'(16)) begin errors++; $display("FAIL restart byte_cnt: got %0d required 16", bus.o_byte_cnt); end
    endtask

    task automatic test_reset_midrun();
        bit ok;
        int base;
        foreach (mem[i]) mem[i] = 8'h20 + 8'(i % 64);
        bus.i_jfif_ready = 1'b1;
        base = got_q.size();
        start_file(40);
        for (int c = 0; c < 20; c++) begin
            @(negedge clk); #1;
            if (got_q.size() - base >= 3) break;
        end
        bus.i_jfif_ready = 1'b0;
        repeat (8) @(posedge clk); #1;
        checks++; if (bus.o_byte_en !== 1'b1) begin errors++; $display("FAIL midrun backlog: got byte_en %b required 1", bus.o_byte_en); end
        @(posedge clk); #3;
        rst = 1'b1;
        #1;
        checks++; if ({bus.o_rd_en, bus.o_byte_en, bus.o_busy, bus.o_done, bus.o_eoi_err} !== 5'b0) begin
            errors++; $display("FAIL midrun reset flags: got %b required 00000", {bus.o_rd_en, bus.o_byte_en, bus.o_busy, bus.o_done, bus.o_eoi_err});
        end
        checks++; if ({bus.o_rd_addr, bus.o_byte, bus.o_byte_cnt} !== '0) begin
            errors++; $display("FAIL midrun reset values: got addr %h byte %h cnt %h required 0", bus.o_rd_addr, bus.o_byte, bus.o_byte_cnt);
        end
        @(posedge clk); #1 rst = 1'b0;
        bus.i_jfif_ready = 1'b1;
        repeat (3) @(posedge clk); #1;
        checks++; if ({bus.o_busy, bus.o_rd_en, bus.o_byte_en} !== 3'b000) begin
            errors++; $display("FAIL post_reset activity: got %b required 000", {bus.o_busy, bus.o_rd_en, bus.o_byte_en});
        end
        build_expect(40);
        base = got_q.size();
        start_file(40);
        wait_done(300, 1'b0, ok);
        repeat (2) @(posedge clk); #1;
        checks++; if (!ok || !seq_ok(base)) begin errors++; $display("FAIL post_reset bytes: got %0d bytes (done %b), required %0d", got_q.size() - base, ok, exp_q.size()); end
        checks++; if (done_err !== exp_err) begin errors++; $display("FAIL post_reset eoi_err: got %b required %b", done_err, exp_err); end
    endtask

    initial begin
        bus.i_start      = 1'b0;
        bus.i_abort      = 1'b0;
        bus.i_len        = '0;
        bus.i_jfif_ready = 1'b0;
        test_reset();
        test_eoi_stream();
        test_random_ready();
        test_exhaust();
        test_d9_latency();
        test_zero_len();
        test_abort();
        test_reset_midrun();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
`default_nettype wire
